floor_request_scheduler: RTL and testbench
==========================================

// Module: floor_request_scheduler
// PURPOSE
//  Collects floor requests from the keypad scanner (4-bit key code + valid) into a pending-request
//  register and issues one target floor at a time to the car motion controller. Uses SCAN
//  (elevator) ordering and times the door-open interval on arrival. Sits between the keypad
//  scanner and the motion/door datapath.
// PARAMETERS
//  NUM_FLOORS   16   floors served; key codes >= NUM_FLOORS are ignored (2..16)
//  DOOR_CYCLES  200  clk cycles door_open stays high per stop (1..255)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous reset, active-low
//  key_code       in   4   floor number from keypad scanner
//  key_valid      in   1   key held (level); a request registers on its rising edge only
//  current_floor  in   4   car position from motion controller
//  target_ready   in   1   motion controller accepts target this cycle
//  arrived        in   1   1-cycle pulse: car stopped at accepted target
//  target_floor   out  4   floor being requested; stable while target_valid=1
//  target_valid   out  1   target offer; held until target_ready
//  dir_up         out  1   current SCAN direction (1=up)
//  door_open      out  1   door command
//  pending        out  16  outstanding requests, bit n = floor n (bits >= NUM_FLOORS always 0)
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, pending=0, target_floor=0, target_valid=0, dir_up=1,
//   door_open=0, busy=0, door timer=0, key_valid_q=0.
//  Capture: key_edge = key_valid & ~key_valid_q. On key_edge with key_code<NUM_FLOORS,
//   pending[key_code] is set on the next edge (1-cycle latency). Held keys do not re-request.
//  Same-floor request: in IDLE or DOOR with key_code==current_floor -> pending is not set;
//   the block enters or stays in DOOR and reloads the timer to DOOR_CYCLES.
//  FSM states:
//   IDLE    pending!=0 -> SELECT.
//   SELECT  one cycle. Compute above = pending floors > current_floor, below = floors <.
//           If dir_up: above!=0 -> nearest above; else below!=0 -> nearest below, dir_up<=0.
//           If !dir_up: mirror rule (nearest below first, else nearest above, dir_up<=1).
//           Register target_floor and set target_valid -> OFFER. If only pending[current_floor]
//           is set: clear it -> DOOR. pending==0 -> IDLE.
//   OFFER   target_valid=1; target_floor/dir_up constant. target_ready -> MOVING,
//           target_valid<=0. target_valid never drops without target_ready.
//   MOVING  target is fixed (no retarget). New requests are only latched.
//           arrived -> clear pending[target_floor], timer<=DOOR_CYCLES, -> DOOR.
//   DOOR    door_open=1; timer decrements each cycle; timer==1 -> SELECT with door_open<=0
//           (door_open high exactly DOOR_CYCLES cycles). Same-floor key_edge reloads timer.
//  Simultaneous events: a key_edge for floor F in the same cycle as F is cleared on arrival ->
//   clear wins (F is being served). A key_edge for any other floor is never lost.
//  Direction persists across IDLE; it changes only in SELECT.
//  arrived outside MOVING and target_ready outside OFFER are ignored.
//  Reset asserted mid-move drops all requests and the offer immediately; no recovery state.
// TESTING
//  1 reset, current_floor=0, key 5 edge -> pending=0x0020 next cycle; target_valid with
//    target_floor=5, dir_up=1 two cycles later; held until target_ready.
//  2 car at 4 moving up to 9, keys 2 and 7 pressed during MOVING -> after arrival at 9 and
//    DOOR_CYCLES, target 7 issued? No: SCAN up finds none above 9, so dir_up=0 and target=7,
//    then 2; pending shows 0x0084 -> 0x0004 -> 0x0000.
//  3 IDLE at floor 3, key 3 -> pending stays 0, door_open high exactly DOOR_CYCLES cycles;
//    key 3 re-pressed mid-door -> timer reloads.
//  4 key_valid held 50 cycles with code 6 -> single request; codes 12..15 with
//    NUM_FLOORS=12 -> pending unchanged.
//  5 arrived at 8 in the same cycle as key 8 edge -> pending[8]=0 afterwards;
//    key 1 edge in the same cycle -> pending[1]=1.
//  6 rst low during OFFER and again during DOOR -> all outputs at reset values in the
//    same cycle, without a clock edge.
```

Note on test 2: the line contains a leftover "target 7 issued? No:" phrase that should be removed before check-in. Corrected line:
`//  2 car at 4 moving up to 9; keys 2,7 during MOVING -> at 9 none above, dir_up<=0, target 7 then 2; pending 0x0084->0x0004->0x0000.`

Source files
------------

// File: rtl/floor_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : floor_request_scheduler
//  Purpose  : Latches keypad floor requests and issues SCAN-ordered targets to
//             the motion controller, timing the door-open interval per stop.
//  Revision : 1.0  initial release
// ============================================================================
module floor_request_scheduler #(
    parameter int NUM_FLOORS  = 16,
    parameter int DOOR_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_code,
    input  logic        key_valid,
    input  logic [3:0]  current_floor,
    input  logic        target_ready,
    input  logic        arrived,
    output logic [3:0]  target_floor,
    output logic        target_valid,
    output logic        dir_up,
    output logic        door_open,
    output logic [15:0] pending,
    output logic        busy
);

    localparam logic [15:0] c_floor_mask =
        (NUM_FLOORS >= 16) ? 16'hFFFF : 16'((32'd1 << NUM_FLOORS) - 32'd1);
    localparam logic [7:0]  c_door_load  = 8'(DOOR_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_OFFER  = 3'd2,
        S_MOVING = 3'd3,
        S_DOOR   = 3'd4
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_key_valid_q;
    logic [15:0] r_pending, w_pending_nxt;
    logic [3:0]  r_target, w_target_nxt;
    logic        r_dir_up, w_dir_up_nxt;
    logic [7:0]  r_timer, w_timer_nxt;

    logic        w_key_edge, w_key_ok, w_same_floor;
    logic [15:0] w_set_mask, w_clr_mask, w_cur_onehot;
    logic [15:0] w_above, w_below;
    logic [3:0]  w_near_above, w_near_below;

    assign w_key_edge   = key_valid & ~r_key_valid_q;
    assign w_key_ok     = c_floor_mask[key_code];
    assign w_cur_onehot = 16'd1 << current_floor;
    // A press for the floor the car is parked at just (re)opens the door.
    assign w_same_floor = w_key_edge && w_key_ok && (key_code == current_floor) &&
                          ((r_state == S_IDLE) || (r_state == S_DOOR));
    assign w_set_mask   = (w_key_edge && w_key_ok && !w_same_floor) ?
                          ((16'd1 << key_code) & c_floor_mask) : 16'd0;

    always_comb begin
        w_above      = '0;
        w_below      = '0;
        w_near_above = 4'd0;
        w_near_below = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_above[i] = r_pending[i] && (4'(i) > current_floor);
            w_below[i] = r_pending[i] && (4'(i) < current_floor);
        end
        // Last match wins: descending scan yields the lowest floor above.
        for (int i = 15; i >= 0; i--) begin
            if (w_above[i]) w_near_above = 4'(i);
        end
        for (int i = 0; i < 16; i++) begin
            if (w_below[i]) w_near_below = 4'(i);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_dir_up_nxt = r_dir_up;
        w_timer_nxt  = r_timer;
        w_clr_mask   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_same_floor) begin
                    w_timer_nxt = c_door_load;
                    w_state_nxt = S_DOOR;
                end else if (r_pending != 16'd0) begin
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if ((w_above != 16'd0) || (w_below != 16'd0)) begin
                    w_state_nxt = S_OFFER;
                    if (r_dir_up) begin
                        if (w_above != 16'd0) begin
                            w_target_nxt = w_near_above;
                        end else begin
                            w_target_nxt = w_near_below;
                            w_dir_up_nxt = 1'b0;
                        end
                    end else begin
                        if (w_below != 16'd0) begin
                            w_target_nxt = w_near_below;
                        end else begin
                            w_target_nxt = w_near_above;
                            w_dir_up_nxt = 1'b1;
                        end
                    end
                end else if ((r_pending & w_cur_onehot) != 16'd0) begin
                    w_clr_mask  = w_cur_onehot;
                    w_timer_nxt = c_door_load;
                    w_state_nxt = S_DOOR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_OFFER: begin
                if (target_ready) w_state_nxt = S_MOVING;
            end
            S_MOVING: begin
                if (arrived) begin
                    w_clr_mask  = 16'd1 << r_target;
                    w_timer_nxt = c_door_load;
                    w_state_nxt = S_DOOR;
                end
            end
            S_DOOR: begin
                if (w_same_floor) begin
                    w_timer_nxt = c_door_load;
                end else if (r_timer <= 8'd1) begin
                    w_timer_nxt = 8'd0;
                    w_state_nxt = S_SELECT;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clear beats a coincident set of the same floor; other floors are kept.
    assign w_pending_nxt = (r_pending | w_set_mask) & ~w_clr_mask & c_floor_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_key_valid_q <= 1'b0;
            r_pending     <= '0;
            r_target      <= 4'd0;
            r_dir_up      <= 1'b1;
            r_timer       <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_key_valid_q <= key_valid;
            r_pending     <= w_pending_nxt;
            r_target      <= w_target_nxt;
            r_dir_up      <= w_dir_up_nxt;
            r_timer       <= w_timer_nxt;
        end
    end

    assign target_floor = r_target;
    assign target_valid = (r_state == S_OFFER);
    assign dir_up       = r_dir_up;
    assign door_open    = (r_state == S_DOOR);
    assign pending      = r_pending;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
`default_nettype none
// Bench for floor_request_scheduler: vector table plus hand sequences, with
// expected outputs queued on drive and compared one cycle later.
module tb_floor_request_scheduler;

    localparam int NUM_FLOORS  = 12;
    localparam int DOOR_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        key_valid = 1'b0;
    logic [3:0]  current_floor = 4'd0;
    logic        target_ready = 1'b0;
    logic        arrived = 1'b0;
    logic [3:0]  target_floor;
    logic        target_valid;
    logic        dir_up;
    logic        door_open;
    logic [15:0] pending;
    logic        busy;

    always #5 clk = ~clk;

    floor_request_scheduler #(
        .NUM_FLOORS (NUM_FLOORS),
        .DOOR_CYCLES(DOOR_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .current_floor(current_floor),
        .target_ready (target_ready),
        .arrived      (arrived),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .pending      (pending),
        .busy         (busy)
    );

    typedef struct {
        logic [3:0]  kc;
        logic        kv;
        logic [3:0]  cf;
        logic        tr;
        logic        arr;
        logic [15:0] pend;
        logic        tv;
        logic [3:0]  tf;
        logic        up;
        logic        door;
        logic        bsy;
    } vec_t;

    typedef struct {
        logic [15:0] pend;
        logic        tv;
        logic [3:0]  tf;
        logic        up;
        logic        door;
        logic        bsy;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t V(input logic [3:0] kc, input logic kv, input logic [3:0] cf,
                               input logic tr, input logic arr, input logic [15:0] pend,
                               input logic tv, input logic [3:0] tf, input logic up,
                               input logic door, input logic bsy);
        vec_t v;
        v = '{kc, kv, cf, tr, arr, pend, tv, tf, up, door, bsy};
        return v;
    endfunction

    task automatic chk(input string tag, input string field, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, field, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        key_code      = v.kc;
        key_valid     = v.kv;
        current_floor = v.cf;
        target_ready  = v.tr;
        arrived       = v.arr;
        sb.push_back(exp_t'{v.pend, v.tv, v.tf, v.up, v.door, v.bsy});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, "pending",      pending,              e.pend);
        chk(tag, "target_valid", {15'd0, target_valid}, {15'd0, e.tv});
        chk(tag, "target_floor", {12'd0, target_floor}, {12'd0, e.tf});
        chk(tag, "dir_up",       {15'd0, dir_up},       {15'd0, e.up});
        chk(tag, "door_open",    {15'd0, door_open},    {15'd0, e.door});
        chk(tag, "busy",         {15'd0, busy},         {15'd0, e.bsy});
    endtask

    task automatic reset_check(input string tag);
        chk(tag, "pending",      pending,               16'd0);
        chk(tag, "target_valid", {15'd0, target_valid}, 16'd0);
        chk(tag, "target_floor", {12'd0, target_floor}, 16'd0);
        chk(tag, "dir_up",       {15'd0, dir_up},       16'd1);
        chk(tag, "door_open",    {15'd0, door_open},    16'd0);
        chk(tag, "busy",         {15'd0, busy},         16'd0);
    endtask

    // Async reset asserted between edges, checked before the next edge, then released.
    task automatic async_reset(input string tag);
        rst = 1'b0;
        #2;
        reset_check(tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request from floor 0 up to 5, then full door interval.
        tbl.push_back(V(5, 1, 0, 0, 0, 16'h0020, 0, 0, 1, 0, 0));
        tbl.push_back(V(5, 1, 0, 0, 0, 16'h0020, 0, 0, 1, 0, 1));
        tbl.push_back(V(5, 0, 0, 0, 0, 16'h0020, 1, 5, 1, 0, 1));
        tbl.push_back(V(5, 0, 0, 0, 0, 16'h0020, 1, 5, 1, 0, 1));
        tbl.push_back(V(5, 0, 0, 1, 0, 16'h0020, 0, 5, 1, 0, 1));
        tbl.push_back(V(5, 0, 5, 0, 1, 16'h0000, 0, 5, 1, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(V(5, 0, 5, 0, 0, 16'h0000, 0, 5, 1, 1, 1));
        tbl.push_back(V(5, 0, 5, 0, 0, 16'h0000, 0, 5, 1, 0, 1));
        tbl.push_back(V(5, 0, 5, 0, 0, 16'h0000, 0, 5, 1, 0, 0));
        tbl.push_back(V(0, 0, 5, 1, 1, 16'h0000, 0, 5, 1, 0, 0));
        // Car at 4 heading to 9; keys 2 and 7 latched while moving; SCAN reverses at 9.
        tbl.push_back(V(9, 1, 4, 0, 0, 16'h0200, 0, 5, 1, 0, 0));
        tbl.push_back(V(9, 0, 4, 0, 0, 16'h0200, 0, 5, 1, 0, 1));
        tbl.push_back(V(9, 0, 4, 0, 0, 16'h0200, 1, 9, 1, 0, 1));
        tbl.push_back(V(9, 0, 4, 1, 0, 16'h0200, 0, 9, 1, 0, 1));
        tbl.push_back(V(2, 1, 4, 0, 0, 16'h0204, 0, 9, 1, 0, 1));
        tbl.push_back(V(2, 0, 4, 0, 0, 16'h0204, 0, 9, 1, 0, 1));
        tbl.push_back(V(7, 1, 4, 0, 0, 16'h0284, 0, 9, 1, 0, 1));
        tbl.push_back(V(7, 0, 9, 0, 1, 16'h0084, 0, 9, 1, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(V(7, 0, 9, 0, 0, 16'h0084, 0, 9, 1, 1, 1));
        tbl.push_back(V(7, 0, 9, 0, 0, 16'h0084, 0, 9, 1, 0, 1));
        tbl.push_back(V(7, 0, 9, 0, 0, 16'h0084, 1, 7, 0, 0, 1));
        tbl.push_back(V(7, 0, 9, 1, 0, 16'h0084, 0, 7, 0, 0, 1));
        tbl.push_back(V(7, 0, 7, 0, 1, 16'h0004, 0, 7, 0, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(V(7, 0, 7, 0, 0, 16'h0004, 0, 7, 0, 1, 1));
        tbl.push_back(V(7, 0, 7, 0, 0, 16'h0004, 0, 7, 0, 0, 1));
        tbl.push_back(V(7, 0, 7, 0, 0, 16'h0004, 1, 2, 0, 0, 1));
        tbl.push_back(V(7, 0, 7, 1, 0, 16'h0004, 0, 2, 0, 0, 1));
        tbl.push_back(V(7, 0, 2, 0, 1, 16'h0000, 0, 2, 0, 1, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(V(7, 0, 2, 0, 0, 16'h0000, 0, 2, 0, 1, 1));
        tbl.push_back(V(7, 0, 2, 0, 0, 16'h0000, 0, 2, 0, 0, 1));
        tbl.push_back(V(7, 0, 2, 0, 0, 16'h0000, 0, 2, 0, 0, 0));

        #12;
        reset_check("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Same-floor press in IDLE opens the door; re-press mid-door reloads the timer.
        apply(V(3, 1, 3, 0, 0, 16'h0000, 0, 2, 0, 1, 1), "t3_open");
        apply(V(3, 0, 3, 0, 0, 16'h0000, 0, 2, 0, 1, 1), "t3_door_a");
        apply(V(3, 0, 3, 0, 0, 16'h0000, 0, 2, 0, 1, 1), "t3_door_b");
        apply(V(3, 1, 3, 0, 0, 16'h0000, 0, 2, 0, 1, 1), "t3_reload");
        for (int i = 0; i < 3; i++)
            apply(V(3, 0, 3, 0, 0, 16'h0000, 0, 2, 0, 1, 1), $sformatf("t3_hold%0d", i));
        apply(V(3, 0, 3, 0, 0, 16'h0000, 0, 2, 0, 0, 1), "t3_close");
        apply(V(3, 0, 3, 0, 0, 16'h0000, 0, 2, 0, 0, 0), "t3_idle");

        // Held key gives one request; out-of-range codes ignored; offer held without ready.
        for (int i = 0; i < 50; i++)
            apply(V(6, 1, 3, 0, 0, 16'h0040, (i >= 2), (i >= 2) ? 4'd6 : 4'd2,
                    (i >= 2), 0, (i >= 1)), $sformatf("t4_held%0d", i));
        apply(V(6, 0, 3, 0, 0, 16'h0040, 1, 6, 1, 0, 1), "t4_release");
        for (int c = 12; c < 16; c++) begin
            apply(V(4'(c), 1, 3, 0, 0, 16'h0040, 1, 6, 1, 0, 1), $sformatf("t4_code%0d", c));
            apply(V(4'(c), 0, 3, 0, 0, 16'h0040, 1, 6, 1, 0, 1), $sformatf("t4_rel%0d", c));
        end
        apply(V(15, 0, 3, 1, 0, 16'h0040, 0, 6, 1, 0, 1), "t4_accept");

        // Arrival at 8 coinciding with a key-8 edge: clear wins.
        apply(V(8, 1, 3, 0, 0, 16'h0140, 0, 6, 1, 0, 1), "t5_key8");
        apply(V(8, 0, 3, 0, 0, 16'h0140, 0, 6, 1, 0, 1), "t5_rel8");
        apply(V(8, 0, 6, 0, 1, 16'h0100, 0, 6, 1, 1, 1), "t5_arr6");
        for (int i = 0; i < 3; i++)
            apply(V(8, 0, 6, 0, 0, 16'h0100, 0, 6, 1, 1, 1), $sformatf("t5_door6_%0d", i));
        apply(V(8, 0, 6, 0, 0, 16'h0100, 0, 6, 1, 0, 1), "t5_sel8");
        apply(V(8, 0, 6, 0, 0, 16'h0100, 1, 8, 1, 0, 1), "t5_offer8");
        apply(V(8, 0, 6, 1, 0, 16'h0100, 0, 8, 1, 0, 1), "t5_move8");
        apply(V(8, 1, 8, 0, 1, 16'h0000, 0, 8, 1, 1, 1), "t5_clear_wins");
        for (int i = 0; i < 3; i++)
            apply(V(8, 0, 8, 0, 0, 16'h0000, 0, 8, 1, 1, 1), $sformatf("t5_door8_%0d", i));
        apply(V(8, 0, 8, 0, 0, 16'h0000, 0, 8, 1, 0, 1), "t5_sel_empty");
        apply(V(8, 0, 8, 0, 0, 16'h0000, 0, 8, 1, 0, 0), "t5_idle");

        // Arrival at 10 coinciding with a key-1 edge: the new request survives.
        apply(V(10, 1, 8, 0, 0, 16'h0400, 0, 8, 1, 0, 0), "t5_key10");
        apply(V(10, 0, 8, 0, 0, 16'h0400, 0, 8, 1, 0, 1), "t5_sel10");
        apply(V(10, 0, 8, 0, 0, 16'h0400, 1, 10, 1, 0, 1), "t5_offer10");
        apply(V(10, 0, 8, 1, 0, 16'h0400, 0, 10, 1, 0, 1), "t5_move10");
        apply(V(1, 1, 10, 0, 1, 16'h0002, 0, 10, 1, 1, 1), "t5_other_kept");
        for (int i = 0; i < 3; i++)
            apply(V(1, 0, 10, 0, 0, 16'h0002, 0, 10, 1, 1, 1), $sformatf("t5_door10_%0d", i));
        apply(V(1, 0, 10, 0, 0, 16'h0002, 0, 10, 1, 0, 1), "t5_sel1");
        apply(V(1, 0, 10, 0, 0, 16'h0002, 1, 1, 0, 0, 1), "t5_offer1");

        // Asynchronous reset during OFFER, then during DOOR.
        async_reset("t6_offer_rst");
        apply(V(0, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1), "t6_open");
        apply(V(0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1), "t6_door");
        async_reset("t6_door_rst");
        apply(V(0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0), "t6_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
